// File: rtl/id_stage_if.sv
// ---------------------------------------------------------------------------
// core package and id_stage_if interface
//
// Purpose: shared pipeline-register types for the RV32I decode stage, and the
// interface bundling every non-clock/reset signal of id_stage.
//
// core package:
//   if_id_t   : fetch -> decode register {pc, inst, valid}
//   id_ex_t   : decode -> execute register
//   id_ex_rst : reset value of id_ex_t (all zero, valid=0)
//
// id_stage_if signals:
//   en        stage enable
//   next_rdy  execute stage can accept id_ex this cycle
//   flush     redirect; kill the instruction being decoded
//   if_id     upstream register
//   wb_en     register-file write enable
//   wb_rd     register-file write index
//   wb_data   register-file write data
//   id_ex     output register to execute
//   rdy       stage consumed if_id this cycle
//
// Modports: slave = id_stage itself, master = the surrounding pipeline/bench.
// ---------------------------------------------------------------------------
package core;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        is_jump;
    logic        wr_rd;
    logic        illegal;
    logic        valid;
  } id_ex_t;

  localparam id_ex_t id_ex_rst = '0;

endpackage

interface id_stage_if;
  logic         en;
  logic         next_rdy;
  logic         flush;
  core::if_id_t if_id;
  logic         wb_en;
  logic [4:0]   wb_rd;
  logic [31:0]  wb_data;
  core::id_ex_t id_ex;
  logic         rdy;

  modport slave (
    input  en, next_rdy, flush, if_id, wb_en, wb_rd, wb_data,
    output id_ex, rdy
  );

  modport master (
    output en, next_rdy, flush, if_id, wb_en, wb_rd, wb_data,
    input  id_ex, rdy
  );
endinterface

// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage -- RV32I instruction decode stage
//
// Purpose: decodes the fetched instruction, reads the 32x32 register file it
// owns, registers the result into id_ex for execute, inserts a one-cycle
// bubble on load-use hazards and kills the decoded instruction on flush.
//
// Ports:
//   clk   clock, all state updates on posedge
//   rst   synchronous active-high reset
//   bus   id_stage_if.slave (en, next_rdy, flush, if_id, wb_* in;
//         id_ex, rdy out)
//
// Configuration macro: CORE_ID_WB_BYPASS_EN
//   defined   : a writeback to a register being read this cycle is forwarded
//               straight into the decode result, no stall.
//   undefined : such a collision stalls one cycle; the instruction decodes
//               the next cycle from the updated register file.
// ---------------------------------------------------------------------------
module id_stage (
  input logic      clk,
  input logic      rst,
  id_stage_if.slave bus
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [31:0]  regs [32];
  logic [31:0]  inst;
  logic [4:0]   rs1;
  logic [4:0]   rs2;
  logic [4:0]   rd;
  logic [31:0]  rs1_data;
  logic [31:0]  rs2_data;
  logic         rs1_used;
  logic         rs2_used;
  logic         writes_rd;
  logic         load_use;
  logic         wb_hit;
  logic         hazard;
  core::id_ex_t dec;
  core::id_ex_t id_ex_q;

  assign inst = bus.if_id.inst;
  assign rs1  = inst[19:15];
  assign rs2  = inst[24:20];
  assign rd   = inst[11:7];

  // Register file; x0 is never written so it always reads back zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.wb_en && bus.wb_rd != 5'd0) begin
      regs[bus.wb_rd] <= bus.wb_data;
    end
  end

  // Combinational read ports, optionally forwarding the same-cycle writeback.
  always_comb begin
    rs1_data = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    rs2_data = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
`ifdef CORE_ID_WB_BYPASS_EN
    if (bus.wb_en && bus.wb_rd != 5'd0 && bus.wb_rd == rs1) rs1_data = bus.wb_data;
    if (bus.wb_en && bus.wb_rd != 5'd0 && bus.wb_rd == rs2) rs2_data = bus.wb_data;
`endif
  end

  // Opcode decode: immediate format, control flags and which sources are read.
  // Every legal opcode already carries inst[1:0]==2'b11, so the default arm
  // also catches compressed/invalid encodings.
  always_comb begin
    dec          = core::id_ex_rst;
    rs1_used     = 1'b0;
    rs2_used     = 1'b0;
    writes_rd    = 1'b0;
    dec.pc       = bus.if_id.pc;
    dec.inst     = inst;
    dec.rs1      = rs1;
    dec.rs2      = rs2;
    dec.rd       = rd;
    dec.opcode   = inst[6:0];
    dec.funct3   = inst[14:12];
    dec.funct7b5 = inst[30];
    dec.rs1_data = rs1_data;
    dec.rs2_data = rs2_data;
    dec.valid    = bus.if_id.valid;
    case (inst[6:0])
      OP_LUI, OP_AUIPC: begin
        dec.imm   = {inst[31:12], 12'b0};
        writes_rd = 1'b1;
      end
      OP_JAL: begin
        dec.imm     = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
        dec.is_jump = 1'b1;
        writes_rd   = 1'b1;
      end
      OP_JALR: begin
        dec.imm     = {{20{inst[31]}}, inst[31:20]};
        dec.is_jump = 1'b1;
        writes_rd   = 1'b1;
        rs1_used    = 1'b1;
      end
      OP_BRANCH: begin
        dec.imm       = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
        dec.is_branch = 1'b1;
        rs1_used      = 1'b1;
        rs2_used      = 1'b1;
      end
      OP_LOAD: begin
        dec.imm     = {{20{inst[31]}}, inst[31:20]};
        dec.is_load = 1'b1;
        writes_rd   = 1'b1;
        rs1_used    = 1'b1;
      end
      OP_STORE: begin
        dec.imm      = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        dec.is_store = 1'b1;
        rs1_used     = 1'b1;
        rs2_used     = 1'b1;
      end
      OP_IMM: begin
        dec.imm   = {{20{inst[31]}}, inst[31:20]};
        writes_rd = 1'b1;
        rs1_used  = 1'b1;
      end
      OP_OP: begin
        writes_rd = 1'b1;
        rs1_used  = 1'b1;
        rs2_used  = 1'b1;
      end
      OP_MISC, OP_SYSTEM: begin
        dec.imm = {{20{inst[31]}}, inst[31:20]};
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
    dec.wr_rd = writes_rd && (rd != 5'd0);
  end

  // Hazards: a load sitting in id_ex whose result is needed now, and (without
  // the bypass) a writeback landing on a register being read this cycle.
  always_comb begin
    load_use = bus.if_id.valid && id_ex_q.valid && id_ex_q.is_load &&
               (id_ex_q.rd != 5'd0) &&
               ((rs1_used && rs1 == id_ex_q.rd) || (rs2_used && rs2 == id_ex_q.rd));
    wb_hit   = bus.wb_en && (bus.wb_rd != 5'd0) &&
               ((rs1_used && rs1 == bus.wb_rd) || (rs2_used && rs2 == bus.wb_rd));
`ifdef CORE_ID_WB_BYPASS_EN
    hazard   = load_use;
`else
    hazard   = load_use || (bus.if_id.valid && wb_hit);
`endif
  end

  assign bus.rdy = bus.en && bus.next_rdy && !hazard && !bus.flush;

  // Output register: reset, then flush, then advance/bubble, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex_q <= core::id_ex_rst;
    end else if (bus.flush) begin
      id_ex_q.valid <= 1'b0;
    end else if (bus.next_rdy) begin
      if (hazard || !bus.en) begin
        id_ex_q.valid <= 1'b0;
      end else begin
        id_ex_q <= dec;
      end
    end
  end

  assign bus.id_ex = id_ex_q;

endmodule

// File: tb/tb_id_stage.sv
// ---------------------------------------------------------------------------
// tb_id_stage -- directed testbench for id_stage
//
// Drives hand-encoded RV32I instructions through the decode stage and checks
// id_ex / rdy against hand-computed values. Covers reset, immediate decode,
// load-use stall, writeback collision (either build), flush, illegal opcode,
// enable and downstream back-pressure.
// ---------------------------------------------------------------------------
module tb_id_stage;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  id_stage_if bus ();

  id_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Count one comparison and report it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one instruction on the upstream register.
  task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] inst, input logic valid);
    bus.if_id.pc    = pc;
    bus.if_id.inst  = inst;
    bus.if_id.valid = valid;
  endtask

  // Advance one clock; outputs are then sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Write a register through the writeback port with no valid instruction.
  task automatic writeReg(input logic [4:0] idx, input logic [31:0] data);
    applyStimulus(32'h0, 32'h0000_0013, 1'b0);
    bus.wb_en   = 1'b1;
    bus.wb_rd   = idx;
    bus.wb_data = data;
    step();
    bus.wb_en   = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    bus.en       = 1'b0;
    bus.next_rdy = 1'b0;
    bus.flush    = 1'b0;
    bus.wb_en    = 1'b0;
    bus.wb_rd    = 5'd0;
    bus.wb_data  = 32'd0;
    applyStimulus(32'h0, 32'h0, 1'b0);
    #1;
    checkOutput("rdy_in_reset", 32'(bus.rdy), 32'd0);
    step();
    step();
    checkOutput("reset_valid", 32'(bus.id_ex.valid), 32'd0);
    checkOutput("reset_pc", bus.id_ex.pc, 32'd0);

    rst          = 1'b0;
    bus.en       = 1'b1;
    bus.next_rdy = 1'b1;
    writeReg(5'd5, 32'h0000_0055);

    // addi x5,x0,10
    applyStimulus(32'h100, 32'h00A0_0293, 1'b1);
    #1;
    checkOutput("addi_rdy", 32'(bus.rdy), 32'd1);
    step();
    checkOutput("addi_pc", bus.id_ex.pc, 32'h100);
    checkOutput("addi_rd", 32'(bus.id_ex.rd), 32'd5);
    checkOutput("addi_imm", bus.id_ex.imm, 32'd10);
    checkOutput("addi_rs1_data", bus.id_ex.rs1_data, 32'd0);
    checkOutput("addi_wr_rd", 32'(bus.id_ex.wr_rd), 32'd1);
    checkOutput("addi_valid", 32'(bus.id_ex.valid), 32'd1);

    // one-cycle reset with a live id_ex
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("rst2_valid", 32'(bus.id_ex.valid), 32'd0);
    checkOutput("rst2_pc", bus.id_ex.pc, 32'd0);

    // addi x6,x5,0 : x5 must have been cleared by reset
    applyStimulus(32'h104, 32'h0002_8313, 1'b1);
    step();
    checkOutput("x5_cleared", bus.id_ex.rs1_data, 32'd0);
    checkOutput("x5_read_rd", 32'(bus.id_ex.rd), 32'd6);

    // beq x0,x0,-16
    applyStimulus(32'h108, 32'hFE00_08E3, 1'b1);
    step();
    checkOutput("beq_imm", bus.id_ex.imm, 32'hFFFF_FFF0);
    checkOutput("beq_is_branch", 32'(bus.id_ex.is_branch), 32'd1);
    checkOutput("beq_wr_rd", 32'(bus.id_ex.wr_rd), 32'd0);

    writeReg(5'd2, 32'h0000_0022);

    // lw x6,0(x1) followed by add x7,x6,x2
    applyStimulus(32'h200, 32'h0000_A303, 1'b1);
    step();
    checkOutput("lw_is_load", 32'(bus.id_ex.is_load), 32'd1);
    checkOutput("lw_rd", 32'(bus.id_ex.rd), 32'd6);
    applyStimulus(32'h204, 32'h0023_03B3, 1'b1);
    #1;
    checkOutput("lu_stall_rdy", 32'(bus.rdy), 32'd0);
    step();
    checkOutput("lu_bubble_valid", 32'(bus.id_ex.valid), 32'd0);
    checkOutput("lu_release_rdy", 32'(bus.rdy), 32'd1);
    step();
    checkOutput("add_valid", 32'(bus.id_ex.valid), 32'd1);
    checkOutput("add_pc", bus.id_ex.pc, 32'h204);
    checkOutput("add_rs2_data", bus.id_ex.rs2_data, 32'h22);

    // writeback collision: add x4,x3,x0 while x3 is being written
    applyStimulus(32'h300, 32'h0001_8233, 1'b1);
    bus.wb_en   = 1'b1;
    bus.wb_rd   = 5'd3;
    bus.wb_data = 32'hDEAD_BEEF;
    #1;
`ifdef CORE_ID_WB_BYPASS_EN
    checkOutput("wb_bypass_rdy", 32'(bus.rdy), 32'd1);
    step();
    bus.wb_en = 1'b0;
`else
    checkOutput("wb_stall_rdy", 32'(bus.rdy), 32'd0);
    step();
    bus.wb_en = 1'b0;
    checkOutput("wb_bubble_valid", 32'(bus.id_ex.valid), 32'd0);
    #1;
    checkOutput("wb_release_rdy", 32'(bus.rdy), 32'd1);
    step();
`endif
    checkOutput("wb_rs1_data", bus.id_ex.rs1_data, 32'hDEAD_BEEF);
    checkOutput("wb_valid", 32'(bus.id_ex.valid), 32'd1);

    // flush kills the incoming instruction, other fields hold
    applyStimulus(32'h400, 32'h00A0_0293, 1'b1);
    bus.flush = 1'b1;
    #1;
    checkOutput("flush_rdy", 32'(bus.rdy), 32'd0);
    step();
    bus.flush = 1'b0;
    checkOutput("flush_valid", 32'(bus.id_ex.valid), 32'd0);
    checkOutput("flush_pc_hold", bus.id_ex.pc, 32'h300);

    // illegal opcode
    applyStimulus(32'h500, 32'h0000_007F, 1'b1);
    step();
    checkOutput("ill_illegal", 32'(bus.id_ex.illegal), 32'd1);
    checkOutput("ill_wr_rd", 32'(bus.id_ex.wr_rd), 32'd0);
    checkOutput("ill_valid", 32'(bus.id_ex.valid), 32'd1);

    // stage disabled -> bubble
    applyStimulus(32'h600, 32'h00A0_0293, 1'b1);
    bus.en = 1'b0;
    #1;
    checkOutput("dis_rdy", 32'(bus.rdy), 32'd0);
    step();
    checkOutput("dis_valid", 32'(bus.id_ex.valid), 32'd0);
    bus.en = 1'b1;
    step();
    checkOutput("en_pc", bus.id_ex.pc, 32'h600);

    // execute not ready -> hold
    applyStimulus(32'h604, 32'h0002_8313, 1'b1);
    bus.next_rdy = 1'b0;
    #1;
    checkOutput("hold_rdy", 32'(bus.rdy), 32'd0);
    step();
    checkOutput("hold_pc", bus.id_ex.pc, 32'h600);
    checkOutput("hold_valid", 32'(bus.id_ex.valid), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
